// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared FSM encoding, MEM/WB payload layout and alignment constants for the MEM stage
package mem_stage_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic        memtoreg;
        logic [4:0]  write_reg;
        logic [63:0] read_data;
        logic [63:0] alu_result;
    } wb_t;

    localparam wb_t WB_BUBBLE = '0;
    localparam int DWORD_ALIGN_BITS = 3;

endpackage

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register that captures either the offered payload or a bubble every cycle
module mem_wb_reg
    import mem_stage_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic bubble,
    input  wb_t  d,
    output wb_t  q
);

    // capture the payload, or squash to a bubble when nothing is retiring this cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q <= WB_BUBBLE;
        else      q <= bubble ? WB_BUBBLE : d;
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM stage with branch resolution, req/ack data-memory access FSM and MEM/WB register
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [63:0] pc_in,
    input  logic        zero_in,
    input  logic [63:0] alu_result_in,
    input  logic [63:0] store_data_in,
    input  logic [4:0]  write_reg_in,
    input  logic        branch_in,
    input  logic        memwrite_in,
    input  logic        memread_in,
    input  logic        memtoreg_in,
    input  logic        regwrite_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    input  logic [63:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic        pc_src,
    output logic [63:0] branch_target,
    output logic        mem_err,
    output logic        wb_valid,
    output logic        wb_regwrite,
    output logic        wb_memtoreg,
    output logic [4:0]  wb_write_reg,
    output logic [63:0] wb_read_data,
    output logic [63:0] wb_alu_result
);

    localparam int CW = $clog2(TIMEOUT);

    state_t          state, state_nx;
    logic [CW-1:0]   cnt;
    logic            req_regwrite, req_memtoreg;
    logic [4:0]      req_write_reg;
    logic            memop, aligned, start, misalign, timeout, wb_bubble;
    wb_t             wb_d, wb_q;

    assign memop    = valid_in & (memread_in | memwrite_in);
    assign aligned  = alu_result_in[DWORD_ALIGN_BITS-1:0] == '0;
    assign start    = (state == IDLE) & memop & aligned;
    assign misalign = (state == IDLE) & memop & ~aligned;
    assign timeout  = (state == ACCESS) & ~dmem_ack & (cnt == CW'(TIMEOUT - 1));
    assign branch_target = pc_in;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // next state: enter ACCESS on an aligned memop, leave on ack or timeout
    always_comb begin
        state_nx = (state == IDLE) ? (start ? ACCESS : IDLE) : ((dmem_ack | timeout) ? IDLE : ACCESS);
    end

    // outputs: handshake, stall, branch decode and the MEM/WB payload selection
    always_comb begin
        dmem_req  = state == ACCESS;
        stall     = start | (dmem_req & ~dmem_ack & ~timeout);
        pc_src    = (state == IDLE) & valid_in & branch_in & zero_in;
        wb_bubble = (state == IDLE) ? (~valid_in | memop) : ~dmem_ack;
        wb_d      = (state == IDLE)
                  ? {1'b1, regwrite_in, memtoreg_in, write_reg_in, 64'd0, alu_result_in}
                  : {1'b1, req_regwrite, req_memtoreg, req_write_reg, dmem_we ? 64'd0 : dmem_rdata, dmem_addr};
    end

    // latch the request so address/data stay stable for the whole access; memwrite wins over memread
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            req_regwrite  <= 1'b0;
            req_memtoreg  <= 1'b0;
            req_write_reg <= '0;
        end else if (start) begin
            dmem_we       <= memwrite_in;
            dmem_addr     <= alu_result_in;
            dmem_wdata    <= store_data_in;
            req_regwrite  <= regwrite_in;
            req_memtoreg  <= memtoreg_in;
            req_write_reg <= write_reg_in;
        end
    end

    // count ACCESS cycles spent waiting; cleared whenever the FSM leaves ACCESS
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt <= '0;
        else      cnt <= (state == ACCESS && state_nx == ACCESS) ? cnt + 1'b1 : '0;
    end

    // sticky error on misaligned access or timeout, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                     mem_err <= 1'b0;
        else if (misalign | timeout)  mem_err <= 1'b1;
    end

    mem_wb_reg u_mem_wb (
        .clk    (clk),
        .rst    (rst),
        .bubble (wb_bubble),
        .d      (wb_d),
        .q      (wb_q)
    );

    assign wb_valid      = wb_q.valid;
    assign wb_regwrite   = wb_q.regwrite;
    assign wb_memtoreg   = wb_q.memtoreg;
    assign wb_write_reg  = wb_q.write_reg;
    assign wb_read_data  = wb_q.read_data;
    assign wb_alu_result = wb_q.alu_result;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized scoreboard bench for mem_stage with a latency-programmable memory responder
module tb_mem_stage;

    localparam int T = 4;

    logic clk = 1'b0, rst = 1'b0;
    always #5 clk = ~clk;

    logic        valid_in = 0, zero_in = 0, branch_in = 0, memwrite_in = 0, memread_in = 0;
    logic        memtoreg_in = 0, regwrite_in = 0, dmem_ack = 0;
    logic [63:0] pc_in = 0, alu_result_in = 0, store_data_in = 0, dmem_rdata = 0;
    logic [4:0]  write_reg_in = 0;
    logic        dmem_req, dmem_we, stall, pc_src, mem_err, wb_valid, wb_regwrite, wb_memtoreg;
    logic [63:0] dmem_addr, dmem_wdata, branch_target, wb_read_data, wb_alu_result;
    logic [4:0]  wb_write_reg;

    mem_stage #(.TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .pc_in(pc_in), .zero_in(zero_in),
        .alu_result_in(alu_result_in), .store_data_in(store_data_in), .write_reg_in(write_reg_in),
        .branch_in(branch_in), .memwrite_in(memwrite_in), .memread_in(memread_in),
        .memtoreg_in(memtoreg_in), .regwrite_in(regwrite_in), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .stall(stall), .pc_src(pc_src), .branch_target(branch_target), .mem_err(mem_err),
        .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg),
        .wb_write_reg(wb_write_reg), .wb_read_data(wb_read_data), .wb_alu_result(wb_alu_result)
    );

    typedef struct {
        logic        rw;
        logic        mtr;
        logic [4:0]  rd;
        logic [63:0] rdata;
        logic [63:0] alu;
    } exp_t;

    exp_t        q[$];
    int          tests = 0, fails = 0;
    int          plan_k = 0, req_cnt = 0, cyc = 0;
    logic [63:0] plan_rdata = 0, exp_addr = 0, exp_wdata = 0;
    logic        exp_we = 0, err_exp = 0, force_ack = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // memory responder: acks in the planned ACCESS cycle, random acks while idle, checks request stability
    always @(negedge clk) begin
        if (dmem_req) begin
            req_cnt++;
            cyc++;
            dmem_ack   = (cyc == plan_k);
            dmem_rdata = dmem_ack ? plan_rdata : {$urandom, $urandom};
            check("dmem_addr", dmem_addr, exp_addr);
            check("dmem_we", 64'(dmem_we), 64'(exp_we));
            check("dmem_wdata", dmem_wdata, exp_wdata);
        end else begin
            cyc        = 0;
            dmem_ack   = force_ack | ($urandom_range(0, 4) == 0);
            dmem_rdata = {$urandom, $urandom};
        end
    end

    // monitor: every retired writeback must match the oldest expected entry; idle slots must be bubbles
    always @(negedge clk) begin
        if (rst) begin
            if (wb_valid) begin
                if (q.size() == 0) check("wb_unexpected", 64'(wb_valid), 64'd0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    check("wb_regwrite", 64'(wb_regwrite), 64'(e.rw));
                    check("wb_memtoreg", 64'(wb_memtoreg), 64'(e.mtr));
                    check("wb_write_reg", 64'(wb_write_reg), 64'(e.rd));
                    check("wb_read_data", wb_read_data, e.rdata);
                    check("wb_alu_result", wb_alu_result, e.alu);
                end
            end else begin
                check("wb_bubble", 64'(wb_regwrite | wb_memtoreg | (|wb_write_reg) | (|wb_read_data) | (|wb_alu_result)), 64'd0);
            end
        end
    end

    // present one instruction, hold it while stalled, then check stall/request counts and the error flag
    task automatic issue(input logic v, input logic br, input logic z, input logic mw, input logic mr,
                         input logic mtr, input logic rw, input logic [4:0] rd, input logic [63:0] pc,
                         input logic [63:0] alu, input logic [63:0] sd, input int k, input logic [63:0] rdata);
        int   ns, exp_ns;
        logic memop, mis, ok;
        exp_t e;
        @(negedge clk);
        valid_in = v; branch_in = br; zero_in = z; memwrite_in = mw; memread_in = mr;
        memtoreg_in = mtr; regwrite_in = rw; write_reg_in = rd; pc_in = pc;
        alu_result_in = alu; store_data_in = sd;
        memop = v & (mw | mr);
        mis   = alu[2:0] != 3'd0;
        ok    = k >= 1 && k <= T;
        plan_k = k; plan_rdata = rdata; exp_addr = alu; exp_we = mw; exp_wdata = sd; req_cnt = 0;
        if (v && !memop) begin
            e = '{rw, mtr, rd, 64'd0, alu};
            q.push_back(e);
        end else if (memop && !mis && ok) begin
            e = '{rw, mtr, rd, mw ? 64'd0 : rdata, alu};
            q.push_back(e);
        end else if (memop) err_exp = 1'b1;
        exp_ns = (memop && !mis) ? (ok ? k : T) : 0;
        ns = 0;
        for (int c = 0; c <= 20; c++) begin
            #4;
            check("pc_src", 64'(pc_src), (c == 0) ? 64'(v & br & z) : 64'd0);
            check("branch_target", branch_target, pc);
            if (!stall) break;
            ns++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        check("stall_cycles", 64'(ns), 64'(exp_ns));
        check("req_cycles", 64'(req_cnt), 64'(exp_ns));
        check("dmem_req_after", 64'(dmem_req), 64'd0);
        check("mem_err", 64'(mem_err), 64'(err_exp));
    endtask

    int          kind, k;
    logic        v;
    logic [63:0] a;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_dmem_req", 64'(dmem_req), 64'd0);
        check("rst_dmem_we", 64'(dmem_we), 64'd0);
        check("rst_dmem_addr", dmem_addr, 64'd0);
        check("rst_dmem_wdata", dmem_wdata, 64'd0);
        check("rst_mem_err", 64'(mem_err), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_wb_ctrl", 64'({wb_regwrite, wb_memtoreg, wb_write_reg}), 64'd0);
        check("rst_wb_read_data", wb_read_data, 64'd0);
        check("rst_wb_alu_result", wb_alu_result, 64'd0);
        rst = 1'b1;

        issue(1, 0, 0, 0, 0, 0, 1, 5'd5, 64'h0, 64'h2A, 64'h0, 0, 64'h0);
        issue(1, 0, 0, 0, 1, 1, 1, 5'd7, 64'h0, 64'h100, 64'h0, 3, 64'hDEADBEEF);
        issue(1, 0, 0, 1, 0, 0, 0, 5'd0, 64'h0, 64'h108, 64'h55, 1, 64'h0);
        issue(1, 1, 1, 0, 0, 0, 0, 5'd0, 64'h40, 64'h0, 64'h0, 0, 64'h0);
        issue(1, 0, 0, 0, 1, 1, 1, 5'd9, 64'h0, 64'h104, 64'h0, 1, 64'h0);
        issue(1, 0, 0, 0, 1, 1, 1, 5'd9, 64'h0, 64'h180, 64'h0, 0, 64'h0);
        issue(1, 0, 0, 0, 1, 1, 1, 5'd11, 64'h0, 64'h188, 64'h0, T, 64'h1234);

        @(negedge clk);
        valid_in = 1; memread_in = 1; memwrite_in = 0; branch_in = 0; regwrite_in = 1; memtoreg_in = 1;
        write_reg_in = 5'd3; alu_result_in = 64'h200;
        plan_k = 0; exp_addr = 64'h200; exp_we = 0; exp_wdata = store_data_in;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("req_before_rst", 64'(dmem_req), 64'd1);
        rst = 1'b0; valid_in = 0; memread_in = 0; err_exp = 0;
        #1;
        check("rst_mid_req", 64'(dmem_req), 64'd0);
        check("rst_mid_stall", 64'(stall), 64'd0);
        check("rst_mid_pc_src", 64'(pc_src), 64'd0);
        check("rst_mid_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_mid_mem_err", 64'(mem_err), 64'd0);
        check("rst_mid_addr", dmem_addr, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        force_ack = 1'b1;
        repeat (2) @(negedge clk);
        force_ack = 1'b0;
        #4;
        check("late_ack_req", 64'(dmem_req), 64'd0);
        check("late_ack_wb_valid", 64'(wb_valid), 64'd0);
        check("late_ack_mem_err", 64'(mem_err), 64'd0);

        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 3);
            v    = $urandom_range(0, 9) != 0;
            a    = {$urandom, $urandom};
            if ($urandom_range(0, 5) != 0) a[2:0] = 3'b0;
            k    = $urandom_range(0, T + 1);
            issue(v, 1'($urandom), 1'($urandom), kind >= 2, kind == 1 || kind == 3, kind == 1,
                  1'($urandom), 5'($urandom), {$urandom, $urandom}, a, {$urandom, $urandom}, k,
                  {$urandom, $urandom});
        end

        @(negedge clk);
        valid_in = 0;
        repeat (3) @(negedge clk);
        check("queue_drained", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the pipelined 64-bit RISC-V core, directly downstream of the EX/MEM register. Decodes branch resolution from the EX/MEM fields, runs loads and stores against a variable-latency data memory through a req/ack handshake, stalls upstream while an access is outstanding, and owns the MEM/WB pipeline register that feeds writeback.

## Interface
- TIMEOUT, 64: maximum ACCESS cycles without `dmem_ack` before the access is aborted (≥2).
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `valid_in` in 1: EX/MEM slot holds a real instruction.
- `pc_in` in 64: branch target from EX/MEM.
- `zero_in` in 1: ALU zero flag from EX/MEM.
- `alu_result_in` in 64: ALU result / memory address.
- `store_data_in` in 64: rs2 value for stores.
- `write_reg_in` in 5: destination register.
- `branch_in`, `memwrite_in`, `memread_in`, `memtoreg_in`, `regwrite_in` in 1 each: control bits.
- `dmem_req` out 1: access request, held until ack.
- `dmem_we` out 1: 1 = store, 0 = load.
- `dmem_addr` out 64: doubleword address.
- `dmem_wdata` out 64: store data.
- `dmem_rdata` in 64: load data, valid with `dmem_ack`.
- `dmem_ack` in 1: one-cycle completion pulse.
- `stall` out 1: upstream must hold EX/MEM contents and PC.
- `pc_src` out 1: branch taken.
- `branch_target` out 64: equals `pc_in`.
- `mem_err` out 1: sticky error flag (misalign or timeout).
- `wb_valid`, `wb_regwrite`, `wb_memtoreg` out 1 each; `wb_write_reg` out 5; `wb_read_data`, `wb_alu_result` out 64: MEM/WB register.

## Operation
- `memop` = `valid_in & (memread_in | memwrite_in)`; if both set, memwrite wins.
- Misaligned (`alu_result_in[2:0] != 0`) memop: no request; sets `mem_err`; MEM/WB loads a bubble; no stall.
- FSM states IDLE, ACCESS.
  - IDLE: aligned memop → ACCESS, latch address/data/we/control into internal request registers, `stall`=1. Otherwise MEM/WB loads the instruction directly (`wb_read_data`=0).
  - ACCESS: `dmem_req`=1, request fields stable from latches. On `dmem_ack`: MEM/WB loads latched control, `wb_read_data`=`dmem_rdata` for loads (0 for stores), → IDLE. On timeout: MEM/WB loads a bubble, `mem_err`=1, → IDLE.
- `stall` = (IDLE & aligned memop) | (ACCESS & !`dmem_ack` & !timeout).
- `pc_src` = `valid_in & branch_in & zero_in`, combinational, evaluated only in IDLE (forced 0 in ACCESS).
- Bubble: `wb_valid`=`wb_regwrite`=`wb_memtoreg`=0, other wb fields 0.
- While `stall`=1 in IDLE, MEM/WB loads a bubble.
- `mem_err` clears only on reset.

## Timing
- Reset: state IDLE, timeout counter 0, `mem_err`=0, all MEM/WB outputs 0, `dmem_req`=0, `dmem_we`=0, `dmem_addr`=0, `dmem_wdata`=0.
- Reset asserted mid-ACCESS: request dropped immediately; a late `dmem_ack` after reset is ignored (IDLE).
- Non-memory instruction: MEM/WB valid one edge after presentation.
- Memory op, ack in k-th ACCESS cycle (k≥1): `stall` high k cycles total (IDLE cycle plus k−1 ACCESS cycles); MEM/WB loaded at edge ending ACCESS cycle k; latency k+1 edges.
- Counter increments each ACCESS cycle without ack; timeout when counter = TIMEOUT−1 with no ack; counter clears on leaving ACCESS.
- `dmem_ack` in the timeout cycle counts as success.
- `dmem_ack` while IDLE is ignored.
- Back-to-back memops: the next one is accepted in the IDLE cycle immediately after completion.

## Structure
- Shared package: FSM state encoding, bubble constant, `DWORD_ALIGN_BITS`=3.
- Sub-module `mem_wb_reg`: MEM/WB register with async active-low reset and load/bubble select, keeping the pipeline-register pattern of the other stages.

## Test plan
- ALU op (`regwrite`=1, `alu_result`=0x2A, rd=5) → no stall; next edge `wb_alu_result`=0x2A, `wb_write_reg`=5, `wb_valid`=1.
- Load addr 0x100, ack on 3rd ACCESS cycle with rdata 0xDEADBEEF → `stall` high 3 cycles; `dmem_addr` stable 0x100; `wb_read_data`=0xDEADBEEF, `wb_memtoreg`=1.
- Store addr 0x108 data 0x55, ack in 1st ACCESS cycle → `dmem_we`=1, `dmem_wdata`=0x55; one stall cycle; `wb_regwrite`=0.
- Load addr 0x104 → no `dmem_req`; `mem_err`=1; bubble in MEM/WB; `stall`=0.
- TIMEOUT=4, no ack → `dmem_req` high exactly 4 cycles; then bubble, `mem_err`=1, `stall`=0, `dmem_req`=0.
- Branch with `zero_in`=1, `pc_in`=0x40 → `pc_src`=1, `branch_target`=0x40 same cycle; `rst` pulled low mid-ACCESS → all outputs 0, FSM IDLE.
